router_fsm_ctrl: RTL and testbench

//  Packet-level sequencer for the 1-in/3-out router. Decodes the header address,

---
 rtl/router_fsm_ctrl.sv | 81 ++++++++
 tb/tb_router_fsm_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/router_fsm_ctrl.sv
// router_fsm_ctrl: packet sequencer that decodes the header address, waits for the target FIFO to drain, and steps through the load states
module router_fsm_ctrl #(
   parameter int unsigned ADDR_W = 2,
   parameter logic [ADDR_W-1:0] INVALID_ADDR = 2'b11
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pkt_valid,
   input  logic [ADDR_W-1:0] data_in,
   input  logic              fifo_full,
   input  logic              fifo_empty_0,
   input  logic              fifo_empty_1,
   input  logic              fifo_empty_2,
   input  logic              soft_reset_0,
   input  logic              soft_reset_1,
   input  logic              soft_reset_2,
   input  logic              parity_done,
   input  logic              low_pkt_valid,
   output logic              detect_add,
   output logic              lfd_state,
   output logic              ld_state,
   output logic              laf_state,
   output logic              full_state,
   output logic              write_enb_reg,
   output logic              rst_int_reg,
   output logic              busy,
   output logic [2:0]        state_o
);
   typedef enum logic [2:0] {
      DECODE       = 3'd0,
      LFD          = 3'd1,
      LOAD_DATA    = 3'd2,
      FIFO_FULL    = 3'd3,
      LAF          = 3'd4,
      LOAD_PARITY  = 3'd5,
      CHECK_PARITY = 3'd6,
      WAIT_EMPTY   = 3'd7
   } state_t;
   state_t state, nxt;
   logic [ADDR_W-1:0] addr_q;
   // Address 3 never names a real port, so its slots read as not-empty / no soft reset
   logic [3:0] empty_v, soft_v;
   assign empty_v = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
   assign soft_v  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
   // State register; addr_q captures the header address only when leaving DECODE
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= DECODE;
         addr_q <= '0;
      end else begin
         state <= nxt;
         if (state == DECODE && nxt != DECODE) addr_q <= data_in;
      end
   end
   // Next-state logic; a soft reset of the selected port pre-empts every transition
   always_comb begin
      nxt = state;
      case (state)
         DECODE:       if (pkt_valid && data_in != INVALID_ADDR)
                          nxt = empty_v[data_in] ? LFD : WAIT_EMPTY;
         WAIT_EMPTY:   nxt = empty_v[addr_q] ? LFD : WAIT_EMPTY;
         LFD:          nxt = LOAD_DATA;
         LOAD_DATA:    nxt = fifo_full ? FIFO_FULL : (!pkt_valid ? LOAD_PARITY : LOAD_DATA);
         FIFO_FULL:    nxt = fifo_full ? FIFO_FULL : LAF;
         LAF:          nxt = parity_done ? DECODE : (low_pkt_valid ? LOAD_PARITY : LOAD_DATA);
         LOAD_PARITY:  nxt = CHECK_PARITY;
         CHECK_PARITY: nxt = fifo_full ? FIFO_FULL : DECODE;
         default:      nxt = DECODE;
      endcase
      if (state != DECODE && soft_v[addr_q]) nxt = DECODE;
   end
   assign detect_add    = state == DECODE;
   assign lfd_state     = state == LFD;
   assign ld_state      = state == LOAD_DATA;
   assign laf_state     = state == LAF;
   assign full_state    = state == FIFO_FULL;
   assign rst_int_reg   = state == CHECK_PARITY;
   assign write_enb_reg = state == LOAD_DATA || state == LOAD_PARITY || state == LAF;
   assign busy          = state != DECODE && state != LOAD_DATA;
   assign state_o       = state;
endmodule

// File: tb/tb_router_fsm_ctrl.sv
// tb_router_fsm_ctrl: directed scoreboard bench for the router packet sequencer
module tb_router_fsm_ctrl;
   logic clock = 0, reset = 1;
   logic pkt_valid = 0, fifo_full = 0, parity_done = 0, low_pkt_valid = 0;
   logic [1:0] data_in = 0;
   logic fifo_empty_0 = 0, fifo_empty_1 = 0, fifo_empty_2 = 0;
   logic soft_reset_0 = 0, soft_reset_1 = 0, soft_reset_2 = 0;
   logic detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy;
   logic [2:0] state_o;
   int checks = 0, errors = 0;
   logic [2:0] q[$];
   router_fsm_ctrl dut (
      .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
      .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
      .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
      .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
      .full_state(full_state), .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg),
      .busy(busy), .state_o(state_o)
   );
   always #5 clock = ~clock;
   // Expected output vector for a state, taken straight from the output definitions
   function automatic logic [10:0] exp_vec(input logic [2:0] s);
      return {s, s == 3'd0, s == 3'd1, s == 3'd2, s == 3'd4, s == 3'd3,
              (s == 3'd2 || s == 3'd5 || s == 3'd4), s == 3'd6,
              !(s == 3'd0 || s == 3'd2)};
   endfunction
   // Monitor: after every edge, compare the registered outputs against the oldest expectation
   always @(posedge clock) begin
      #1;
      if (q.size() > 0) begin
         logic [2:0] s;
         logic [10:0] got;
         s = q.pop_front();
         got = {state_o, detect_add, lfd_state, ld_state, laf_state, full_state,
                write_enb_reg, rst_int_reg, busy};
         checks++;
         if (got !== exp_vec(s)) begin
            errors++;
            $display("FAIL outputs t=%0t got=%b required=%b (state %0d)", $time, got, exp_vec(s), s);
         end
      end
   end
   // Push the state expected after the coming edge, then advance to the next falling edge
   task automatic tick(input logic [2:0] s);
      q.push_back(s);
      @(negedge clock);
   endtask
   initial begin
      @(negedge clock);
      // T1: reset
      tick(0); tick(0);
      reset = 0;
      // T2: packet to port 1, 4 payload cycles
      pkt_valid = 1; data_in = 1; fifo_empty_1 = 1;
      tick(1); tick(2); tick(2); tick(2); tick(2);
      pkt_valid = 0;
      tick(5); tick(6); tick(0); tick(0);
      // T3: port 2 not empty for 5 cycles; WAIT_EMPTY must watch addr_q, not data_in
      pkt_valid = 1; data_in = 2;
      tick(7);
      data_in = 0; fifo_empty_0 = 1;
      tick(7); tick(7); tick(7); tick(7);
      fifo_empty_2 = 1;
      tick(1);
      pkt_valid = 0;
      tick(2); tick(5); tick(6); tick(0);
      pkt_valid = 1; data_in = 3;
      tick(0); tick(0); tick(0);
      // T4a: full stall released with low_pkt_valid
      data_in = 0;
      tick(1); tick(2);
      fifo_full = 1;
      tick(3); tick(3); tick(3);
      fifo_full = 0; low_pkt_valid = 1; pkt_valid = 0;
      tick(4); tick(5);
      low_pkt_valid = 0;
      tick(6); tick(0);
      // T4b: parity_done in LAF
      pkt_valid = 1;
      tick(1); tick(2);
      fifo_full = 1;
      tick(3);
      fifo_full = 0; parity_done = 1;
      tick(4); tick(0);
      parity_done = 0;
      // T4c: LAF back to LOAD_DATA, then full during CHECK_PARITY
      tick(1); tick(2);
      fifo_full = 1;
      tick(3);
      fifo_full = 0;
      tick(4); tick(2);
      pkt_valid = 0;
      tick(5);
      fifo_full = 1;
      tick(6); tick(3);
      fifo_full = 0; parity_done = 1;
      tick(4); tick(0);
      parity_done = 0;
      // T5: soft resets
      pkt_valid = 1; data_in = 0;
      tick(1); tick(2);
      soft_reset_1 = 1;
      tick(2);
      soft_reset_1 = 0;
      tick(2);
      soft_reset_0 = 1; pkt_valid = 0;
      tick(0);
      pkt_valid = 1;
      tick(1);
      tick(0);
      soft_reset_0 = 0;
      tick(1); tick(2);
      reset = 1; soft_reset_0 = 1;
      tick(0);
      reset = 0; soft_reset_0 = 0; pkt_valid = 0;
      tick(0);
      // soft reset while waiting on a busy port
      pkt_valid = 1; data_in = 2; fifo_empty_2 = 0;
      tick(7);
      pkt_valid = 0; soft_reset_2 = 1;
      tick(0);
      soft_reset_2 = 0;
      tick(0);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
